// File: rtl/frame_align_fsm.sv
// Frame aligner: hunts for a 62-bit header, confirms it one frame later, then labels the
// 25 payload words and tail of each frame while flywheeling over corrupted headers.
package frame_align_pkg;

  typedef enum logic [4:0] {
    IDLEB     = 5'd0,
    DATA1     = 5'd1,
    DATA2     = 5'd2,
    DATA3     = 5'd3,
    DATA4     = 5'd4,
    DATA5     = 5'd5,
    DATA6     = 5'd6,
    DATA7     = 5'd7,
    DATA8     = 5'd8,
    DATA9     = 5'd9,
    DATA10    = 5'd10,
    DATA11    = 5'd11,
    DATA12    = 5'd12,
    DATA13    = 5'd13,
    DATA14    = 5'd14,
    DATA15    = 5'd15,
    DATA16    = 5'd16,
    DATA17    = 5'd17,
    DATA18    = 5'd18,
    DATA19    = 5'd19,
    DATA20    = 5'd20,
    DATA21    = 5'd21,
    DATA22    = 5'd22,
    DATA23    = 5'd23,
    DATA24    = 5'd24,
    DATA25    = 5'd25,
    DATA_TAIL = 5'd26
  } frame_state_t;

endpackage

module frame_align_fsm #(
  parameter logic [61:0] SYNC_WORD  = 62'h2AAA_AAAA_AAAA_AAAA,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic                        clk_390p625M,
  input  logic                        rst,
  input  logic [61:0]                 rx_data,
  input  logic                        rx_valid,
  output logic [61:0]                 frame_data,
  output frame_align_pkg::frame_state_t frame_state,
  output logic                        dly_data_tail_flag,
  output logic                        frame_lock,
  output logic [15:0]                 frame_err_cnt
);

  import frame_align_pkg::*;

  localparam logic [4:0] LastWord  = 5'd26;
  localparam logic [2:0] UnlockCnt = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    StHunt,
    StConfirm,
    StLocked
  } align_st_e;

  align_st_e    st_q, st_d;
  logic [4:0]   wcnt_q, wcnt_d;
  logic [2:0]   miss_q, miss_d;
  logic [15:0]  err_q, err_d;
  logic [61:0]  data_q;
  frame_state_t label_q, label_d;
  logic         tail_q;
  logic         lock_q;

  logic [4:0]   wcnt_inc;
  logic         hdr_match;

  assign wcnt_inc  = (wcnt_q == LastWord) ? 5'd0 : wcnt_q + 5'd1;
  assign hdr_match = (rx_data == SYNC_WORD);

  always_comb begin
    st_d    = st_q;
    wcnt_d  = wcnt_q;
    miss_d  = miss_q;
    err_d   = err_q;
    label_d = IDLEB;

    // Payload labels come from the pre-update position; headers always read as IDLEB.
    if (rx_valid && (st_q == StLocked) && (wcnt_q != 5'd0)) begin
      label_d = frame_state_t'(wcnt_q);
    end

    if (rx_valid) begin
      unique case (st_q)
        StHunt: begin
          if (hdr_match) begin
            st_d   = StConfirm;
            wcnt_d = 5'd1;
          end
        end
        StConfirm: begin
          if (wcnt_q == 5'd0) begin
            if (hdr_match) begin
              st_d   = StLocked;
              wcnt_d = 5'd1;
              miss_d = 3'd0;
            end else begin
              st_d   = StHunt;
              wcnt_d = 5'd0;
            end
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        StLocked: begin
          if (wcnt_q == 5'd0) begin
            if (hdr_match) begin
              miss_d = 3'd0;
              wcnt_d = 5'd1;
            end else begin
              if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
              end
              if ((miss_q + 3'd1) >= UnlockCnt) begin
                st_d   = StHunt;
                wcnt_d = 5'd0;
                miss_d = 3'd0;
              end else begin
                // Flywheel: keep frame timing across a bad header.
                miss_d = miss_q + 3'd1;
                wcnt_d = 5'd1;
              end
            end
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        default: begin
          st_d   = StHunt;
          wcnt_d = 5'd0;
          miss_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      st_q    <= StHunt;
      wcnt_q  <= 5'd0;
      miss_q  <= 3'd0;
      err_q   <= 16'd0;
      data_q  <= 62'd0;
      label_q <= IDLEB;
      tail_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      data_q  <= rx_data;
      label_q <= label_d;
      tail_q  <= (label_q == DATA_TAIL);
      lock_q  <= (st_d == StLocked);
    end
  end

  assign frame_data         = data_q;
  assign frame_state        = label_q;
  assign dly_data_tail_flag = tail_q;
  assign frame_lock         = lock_q;
  assign frame_err_cnt      = err_q;

endmodule

// File: doc/frame_align_fsm.md
FRAME_ALIGN_FSM -- requirements
Module: frame_align_fsm

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 62'h2AAA_AAAA_AAAA_AAAA, 62-bit frame header pattern.
REQ-002 SHALL have parameter UNLOCK_CNT, default 3, number of consecutive missed headers that drops lock (range 1..7).
REQ-003 SHALL have port clk_390p625M  input  1  system clock. One clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port rx_data  input  62  descrambled receive word.
REQ-006 SHALL have port rx_valid  input  1  rx_data qualifier.
REQ-007 SHALL have port frame_data  output  62  rx_data registered one cycle.
REQ-008 SHALL have port frame_state  output  frame_state_t  label of frame_data.
REQ-009 SHALL have port dly_data_tail_flag  output  1  one-cycle pulse, frame assembly complete.
REQ-010 SHALL have port frame_lock  output  1  frame alignment achieved.
REQ-011 SHALL have port frame_err_cnt  output  16  missed-header count while locked.

Function
REQ-012 frame_state_t SHALL be a 5-bit encoding: IDLEB=0, DATA1..DATA25=1..25, DATA_TAIL=26; IDLEB means "hold, no payload".
REQ-013 Frame format SHALL be 27 valid words: header (== SYNC_WORD), 25 payload words, 1 tail word (payload in tail bits [61:44]; bits [43:0] not checked).
REQ-014 Internal states SHALL be HUNT, CONFIRM, LOCKED; word counter wcnt 0..26 advances only on rx_valid=1, wraps 26->0; wcnt=0 denotes header position.
REQ-015 HUNT: on valid word == SYNC_WORD -> CONFIRM, wcnt=1; otherwise stay.
REQ-016 CONFIRM: at wcnt=0 (27th valid word after header) word == SYNC_WORD -> LOCKED; mismatch -> HUNT; non-header positions are not checked.
REQ-017 LOCKED: at wcnt=0 a matching header clears miss count; a mismatch increments miss count and frame_err_cnt (saturating at 16'hFFFF) and frame timing continues (flywheel); miss count reaching UNLOCK_CNT -> HUNT, frame_lock=0 that same output cycle.
REQ-018 SYNC_WORD appearing in payload or tail positions SHALL be ignored in LOCKED and CONFIRM.
REQ-019 frame_data/frame_state latency SHALL be 1 cycle; frame_state = DATA<wcnt> for wcnt 1..25, DATA_TAIL for wcnt 26, only in LOCKED with rx_valid=1; otherwise IDLEB (headers, HUNT, CONFIRM, rx_valid=0).
REQ-020 frame_data SHALL update every cycle (including rx_valid=0).
REQ-021 dly_data_tail_flag SHALL be 1 for exactly one cycle, the cycle after frame_state=DATA_TAIL is output (2 cycles after the tail word at input).
REQ-022 frame_lock SHALL rise on the output cycle labelled IDLEB for the confirming header; the first frame after confirmation is labelled DATA1..DATA_TAIL.
REQ-023 The transition LOCKED->HUNT on the tail-to-header boundary SHALL not suppress a pending dly_data_tail_flag.
REQ-024 rx_valid=0 mid-frame SHALL freeze wcnt, state and miss count; labels resume at the next valid word.

Reset
REQ-025 rst=1 SHALL force, at next clock edge: state HUNT, wcnt=0, miss count 0, frame_data=0, frame_state=IDLEB, dly_data_tail_flag=0, frame_lock=0, frame_err_cnt=0.
REQ-026 rst mid-frame SHALL abandon the frame with no tail flag; realignment starts from HUNT after release.

Verification
REQ-027 rst=1 two cycles -> all outputs 0 / IDLEB; release with rx_valid=0 -> unchanged.
REQ-028 SYNC_WORD, 25 words 1..25, tail, SYNC_WORD, then second frame of 26 words -> frame_lock=1 at second header output, labels DATA1..DATA_TAIL with frame_data matching inputs, single tail flag 2 cycles after second tail.
REQ-029 Locked; rx_valid=0 for 3 cycles after DATA7 word -> 3 IDLEB outputs, next valid word labelled DATA8, tail flag timing shifted by 3.
REQ-030 Locked; 2 corrupt headers then good -> lock held, frame_err_cnt=2; then 3 consecutive corrupt headers (UNLOCK_CNT=3) -> frame_lock=0, frame_err_cnt=5, labels IDLEB.
REQ-031 Locked; SYNC_WORD injected as DATA12 word -> labelled DATA12, no realignment, frame_err_cnt unchanged.
REQ-032 rst pulse at DATA15 -> outputs reset next cycle, no tail flag; relock requires two headers 27 valid words apart.
